i2c_request_arbiter: RTL
========================

Name: i2c_request_arbiter

Overview:
- Shares the single i2c_handler transaction engine between NUM_REQ on-chip requesters, e.g. rail sequencer, telemetry poller and host bridge.
- Arbitrates round-robin and latches the winner's address, data and direction.
- Drives a one-cycle begin pulse into the handler, then holds until the handler reports completion.
- Returns completion, ACK status and read data to the granted requester only.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, watchdog limit in i_clk cycles for one transaction (used only with I2C_TIMEOUT_EN).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_req  in  NUM_REQ  per-requester request level.
- i_reqWriteEnable  in  NUM_REQ  per-requester direction (1 = write).
- i_reqAddress  in  7*NUM_REQ  packed 7-bit I2C addresses; requester k uses bits [7k+6:7k].
- i_reqData  in  8*NUM_REQ  packed write bytes; requester k uses bits [8k+7:8k].
- o_grant  out  NUM_REQ  one-hot current owner.
- o_done  out  NUM_REQ  one-cycle completion pulse to the owner.
- o_ackError  out  1  NACK status, valid while any o_done bit is high.
- o_timeout  out  1  watchdog abort status, valid while any o_done bit is high.
- o_readData  out  8  read byte, valid while any o_done bit is high.
- o_begin  out  1  one-cycle start pulse to i2c_handler.
- o_writeEnable  out  1  to handler i_writeEnable.
- o_i2cAddress  out  7  to handler i_i2cAddress.
- o_data  out  8  to handler write data.
- i_busy  in  1  handler busy.
- i_done  in  1  handler one-cycle completion pulse.
- i_handlerAckError  in  1  handler NACK flag, valid with i_done.
- i_handlerReadData  in  8  handler read byte, valid with i_done.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; latched fields 0.
- State IDLE:
  - If any i_req bit is set and i_busy=0, select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Register o_grant and latch that requester's address, data and writeEnable onto o_i2cAddress, o_data and o_writeEnable.
  - Go to ISSUE.
  - If i_busy=1, stay in IDLE; no grant is issued.
- State ISSUE: o_begin=1 for exactly this one cycle; go to WAIT.
- State WAIT:
  - Hold all handler outputs stable.
  - On i_done, capture i_handlerAckError and i_handlerReadData and go to COMPLETE.
  - An i_done arriving in the same cycle as o_begin is ignored.
- State COMPLETE:
  - o_done[owner]=1 for one cycle, with o_ackError, o_readData and o_timeout presented the same cycle.
  - Set pointer = owner+1 modulo NUM_REQ; clear o_grant next cycle; return to IDLE.
- Timing:
  - Request to o_begin latency is 2 cycles (IDLE sample, then ISSUE).
  - At most one transaction is outstanding at a time.
  - Minimum gap between consecutive o_begin pulses is handler latency + 3 cycles.
- Requester contract:
  - Hold i_req and its fields until o_done.
  - The fields are latched at grant, so later changes do not affect the transaction in flight.
  - Dropping i_req after grant does not abort; the transaction completes and o_done is still pulsed.
- Fairness:
  - A requester holding i_req continuously is served at most once per full rotation while others are pending.
  - With only one requester active, it is re-granted back-to-back.
- Reset mid-transaction forces IDLE immediately, with no o_done pulse. The handler is reset by the same i_reset.
- o_ackError and o_timeout are only meaningful while any o_done bit is high and are 0 otherwise.

Optional Feature:
- Macro I2C_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES-1 without i_done, go to COMPLETE with o_timeout=1, o_ackError=1, o_readData=0.
  - A late i_done after the abort, while in IDLE, is discarded.
- Not defined: no counter is built, WAIT persists until i_done, and o_timeout is tied 0.

Test Plan:
- Requester 0 writes, address 7'h12, data 8'h34, handler done after 20 cycles:
  - o_begin pulses once, 2 cycles after i_req;
  - o_i2cAddress=7'h12 and o_data=8'h34 stay stable through WAIT;
  - o_done[0] pulses 1 cycle after i_done, with o_ackError=0.
- i_req=4'b1111 held continuously, pointer 0: grants go 0,1,2,3,0 in order, with exactly one o_begin per grant.
- Requester 2 reads, handler returns i_handlerReadData=8'hA5 and i_handlerAckError=1: o_done[2] pulses with o_readData=8'hA5 and o_ackError=1.
- Requester 1 drops i_req and changes i_reqAddress to 7'h55 one cycle after grant: the transaction still uses the latched address, and o_done[1] still pulses.
- i_reset asserted during WAIT: the next cycle shows all outputs 0 and state IDLE, with no o_done; a fresh request is then served normally.
- With I2C_TIMEOUT_EN and TIMEOUT_CYCLES=64, the handler never asserts i_done: o_done[owner] pulses 64 cycles into WAIT with o_timeout=1, and a late i_done is ignored.

Source files
------------

// File: rtl/i2c_request_arbiter_if.sv
// Requester-side and handler-side signals of i2c_request_arbiter.
// The arbiter connects through slave; the requesters and the handler model connect through master.
interface i2c_request_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_req;
  logic [NUM_REQ-1:0]   i_reqWriteEnable;
  logic [7*NUM_REQ-1:0] i_reqAddress;
  logic [8*NUM_REQ-1:0] i_reqData;
  logic [NUM_REQ-1:0]   o_grant;
  logic [NUM_REQ-1:0]   o_done;
  logic                 o_ackError;
  logic                 o_timeout;
  logic [7:0]           o_readData;
  logic                 o_begin;
  logic                 o_writeEnable;
  logic [6:0]           o_i2cAddress;
  logic [7:0]           o_data;
  logic                 i_busy;
  logic                 i_done;
  logic                 i_handlerAckError;
  logic [7:0]           i_handlerReadData;

  modport slave (
    input  i_req, i_reqWriteEnable, i_reqAddress, i_reqData,
    input  i_busy, i_done, i_handlerAckError, i_handlerReadData,
    output o_grant, o_done, o_ackError, o_timeout, o_readData,
    output o_begin, o_writeEnable, o_i2cAddress, o_data
  );

  modport master (
    output i_req, i_reqWriteEnable, i_reqAddress, i_reqData,
    output i_busy, i_done, i_handlerAckError, i_handlerReadData,
    input  o_grant, o_done, o_ackError, o_timeout, o_readData,
    input  o_begin, o_writeEnable, o_i2cAddress, o_data
  );
endinterface

// File: rtl/i2c_request_arbiter.sv
// Round-robin sharing of one i2c_handler among NUM_REQ requesters; watchdog abort built only with `I2C_TIMEOUT_EN.
// o_begin one cycle after the IDLE sample, o_done one cycle after i_done; one transaction outstanding, i_busy holds off grants.
module i2c_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                  i_clk,
  input logic                  i_reset,
  i2c_request_arbiter_if.slave bus
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_WAIT     = 2'd2;
  localparam logic [1:0] S_COMPLETE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [IDXW-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [6:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               we_q, we_d;
  logic               ack_err_q, ack_err_d;
  logic               tmo_q, tmo_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               sel_vld;
  logic [IDXW-1:0]    sel_idx;
  logic               timeout_hit;

  function automatic logic [IDXW-1:0] rr_index(input logic [IDXW-1:0] base, input int off);
    int k;
    k = int'(base) + off;
    if (k >= NUM_REQ) k = k - NUM_REQ;
    return IDXW'(k);
  endfunction

`ifdef I2C_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;

  // Cleared during ISSUE so the first WAIT cycle counts as zero.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_ISSUE)     wdog_d = '0;
    else if (state_q == S_WAIT) wdog_d = wdog_q + 16'd1;
  end

  assign timeout_hit = (state_q == S_WAIT) && (wdog_q == WDOG_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Scanning from the far end lets the offset closest to the pointer win.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.i_req[rr_index(ptr_q, i)]) begin
        sel_vld = 1'b1;
        sel_idx = rr_index(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = we_q;
    ack_err_d = 1'b0;
    tmo_d     = 1'b0;
    rdata_d   = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (sel_vld && !bus.i_busy) begin
          owner_d          = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          addr_d           = bus.i_reqAddress[7*int'(sel_idx) +: 7];
          data_d           = bus.i_reqData[8*int'(sel_idx) +: 8];
          we_d             = bus.i_reqWriteEnable[sel_idx];
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_done) begin
          ack_err_d = bus.i_handlerAckError;
          rdata_d   = bus.i_handlerReadData;
          state_d   = S_COMPLETE;
        end else if (timeout_hit) begin
          ack_err_d = 1'b1;
          tmo_d     = 1'b1;
          state_d   = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        ptr_d   = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      ack_err_q <= 1'b0;
      tmo_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      ack_err_q <= ack_err_d;
      tmo_q     <= tmo_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.o_grant       = grant_q;
  assign bus.o_done        = (state_q == S_COMPLETE) ? grant_q : '0;
  assign bus.o_ackError    = ack_err_q;
  assign bus.o_timeout     = tmo_q;
  assign bus.o_readData    = rdata_q;
  assign bus.o_begin       = (state_q == S_ISSUE);
  assign bus.o_writeEnable = we_q;
  assign bus.o_i2cAddress  = addr_q;
  assign bus.o_data        = data_q;
endmodule
